// File: rtl/filter_reg_bank_pkg.sv
// rtl/filter_reg_bank_pkg.sv - shared FILTER_CTRL layout, filter type encoding and status register count
package filter_reg_bank_pkg;

  // FILTER_CTRL field layout
  localparam int CTRL_W = 8;
  localparam int FT_OFF = 0;
  localparam int FT_W   = 2;
  localparam int WS_OFF = 2;
  localparam int WS_W   = 4;
  localparam int IE_BIT = 6;
  localparam int WD_BIT = 7;

  typedef enum logic [FT_W-1:0] {
    FT_BYPASS = 2'd0,
    FT_MEAN   = 2'd1,
    FT_MEDIAN = 2'd2,
    FT_MAX    = 2'd3
  } filter_type_e;

  // One 8-bit INT_STATUS register per group of eight channels
  function automatic int calc_ns(input int n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/filter_ctrl_reg.sv
// rtl/filter_ctrl_reg.sv - one FILTER_CTRL register with its field decode
module filter_ctrl_reg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] value_o,
  output logic [1:0] filter_type_o,
  output logic [3:0] window_size_o,
  output logic       int_en_o,
  output logic       wd_rst_o
);
  import filter_reg_bank_pkg::*;

  logic [CTRL_W-1:0] value_q;
  filter_type_e      ftype;

  // Register write; reset has priority over any write in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else if (we_i) begin
      value_q <= wdata_i;
    end
  end

  assign ftype         = filter_type_e'(value_q[FT_OFF +: FT_W]);
  assign value_o       = value_q;
  assign filter_type_o = ftype;
  assign window_size_o = value_q[WS_OFF +: WS_W];
  assign int_en_o      = value_q[IE_BIT];
  assign wd_rst_o      = value_q[WD_BIT];

endmodule

// File: rtl/filter_reg_bank.sv
// rtl/filter_reg_bank.sv - filter control/status register bank; FILTER_REG_BANK_LOCK_EN adds the LOCK register
module filter_reg_bank #(
  parameter int N      = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              acc_en_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  output logic              rvalid_o,
  output logic              err_o,
  output logic [2*N-1:0]    filter_type_o,
  output logic [4*N-1:0]    window_size_o,
  output logic [N-1:0]      int_en_o,
  output logic [N-1:0]      wd_rst_o,
  input  logic [N-1:0]      in_int_i,
  output logic              irq_o
);
  import filter_reg_bank_pkg::*;

  localparam int NS        = calc_ns(N);
  localparam int LOCK_ADDR = N + NS;

  logic [31:0]      addr_ext;
  logic             rd_acc;
  logic             wr_acc;
  logic             ctrl_hit;
  logic             stat_hit;
  logic             lock_hit;
  logic             lock_q;
  logic [N-1:0]     ctrl_we;
  logic [7:0]       ctrl_val [N];
  logic [N-1:0]     status_q;
  logic [N-1:0]     w1c;
  logic [8*NS-1:0]  status_pad;
  logic [7:0]       status_bytes [NS];
  logic [7:0]       rd_data;
  logic             err_d;

  assign addr_ext = 32'(addr_i);
  assign rd_acc   = acc_en_i & ~wr_en_i;
  assign wr_acc   = acc_en_i & wr_en_i;
  assign ctrl_hit = addr_ext < 32'(N);
  assign stat_hit = (addr_ext >= 32'(N)) && (addr_ext < 32'(LOCK_ADDR));

`ifdef FILTER_REG_BANK_LOCK_EN
  assign lock_hit = addr_ext == 32'(LOCK_ADDR);

  // LOCK is set-only; nothing but reset releases it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
    end else if (wr_acc && lock_hit && wdata_i[0]) begin
      lock_q <= 1'b1;
    end
  end
`else
  assign lock_hit = 1'b0;
  assign lock_q   = 1'b0;
`endif

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    assign ctrl_we[ch] = wr_acc & (addr_ext == 32'(ch)) & ~lock_q;

    filter_ctrl_reg u_ctrl (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .we_i          (ctrl_we[ch]),
      .wdata_i       (wdata_i),
      .value_o       (ctrl_val[ch]),
      .filter_type_o (filter_type_o[2*ch +: 2]),
      .window_size_o (window_size_o[4*ch +: 4]),
      .int_en_o      (int_en_o[ch]),
      .wd_rst_o      (wd_rst_o[ch])
    );

    // W1C strobe for this channel's bit in its INT_STATUS byte
    assign w1c[ch] = wr_acc && (addr_ext == 32'(N + ch / 8)) && wdata_i[ch % 8];
  end

  // Sticky status: clear applied first so a same-cycle event keeps the bit set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c) | in_int_i;
    end
  end

  // Channels beyond N read back as zero in the last status byte
  always_comb begin
    status_pad          = '0;
    status_pad[N-1:0]   = status_q;
  end

  for (genvar j = 0; j < NS; j++) begin : g_stat
    assign status_bytes[j] = status_pad[8*j +: 8];
  end

  // Read mux over pre-update register contents; unmapped addresses return 0
  always_comb begin
    rd_data = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (addr_ext == 32'(ch)) rd_data = ctrl_val[ch];
    end
    for (int j = 0; j < NS; j++) begin
      if (addr_ext == 32'(N + j)) rd_data = status_bytes[j];
    end
    if (lock_hit) rd_data = {7'd0, lock_q};
  end

  // Error on unmapped access, or on a FILTER_CTRL write refused by LOCK
  always_comb begin
    err_d = acc_en_i & (~(ctrl_hit | stat_hit | lock_hit) | (wr_en_i & ctrl_hit & lock_q));
  end

  // Registered response and interrupt outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      rdata_o  <= rd_acc ? rd_data : 8'd0;
      rvalid_o <= rd_acc;
      err_o    <= err_d;
      irq_o    <= |(status_q & int_en_o);
    end
  end

endmodule

// File: tb/tb_filter_reg_bank.sv
// tb/tb_filter_reg_bank.sv - randomized bench with behavioural register model for filter_reg_bank
module tb_filter_reg_bank;

  localparam int N      = 8;
  localparam int ADDR_W = 8;
  localparam int NS     = (N + 7) / 8;
`ifdef FILTER_REG_BANK_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              acc = 1'b0;
  logic              wr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        wd = '0;
  logic [N-1:0]      in_int = '0;
  logic [7:0]        rdata;
  logic              rvalid;
  logic              err;
  logic [2*N-1:0]    ft;
  logic [4*N-1:0]    ws;
  logic [N-1:0]      ie;
  logic [N-1:0]      wdr;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [7:0]   m_ctrl [N];
  logic [N-1:0] m_stat;
  logic         m_lock;
  logic [7:0]   exp_rdata;
  logic         exp_rvalid;
  logic         exp_err;
  logic         exp_irq;
  logic         chk_on = 1'b0;

  filter_reg_bank #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .acc_en_i      (acc),
    .wr_en_i       (wr),
    .addr_i        (addr),
    .wdata_i       (wd),
    .rdata_o       (rdata),
    .rvalid_o      (rvalid),
    .err_o         (err),
    .filter_type_o (ft),
    .window_size_o (ws),
    .int_en_o      (ie),
    .wd_rst_o      (wdr),
    .in_int_i      (in_int),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] read_val(input int a);
    logic [7:0] v;
    v = 8'd0;
    if (a < N) begin
      v = m_ctrl[a];
    end else if (a < N + NS) begin
      for (int b = 0; b < 8; b++) begin
        int ch;
        ch = (a - N) * 8 + b;
        if (ch < N) v[b] = m_stat[ch];
      end
    end else if (LOCK_ON && a == N + NS) begin
      v = {7'd0, m_lock};
    end
    return v;
  endfunction

  // one clock edge of the register bank, described from its rules
  task automatic model_step();
    int a;
    bit mapped;
    if (rst) begin
      for (int ch = 0; ch < N; ch++) m_ctrl[ch] = 8'd0;
      m_stat     = '0;
      m_lock     = 1'b0;
      exp_rdata  = 8'd0;
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_irq    = 1'b0;
      chk_on     = 1'b1;
      return;
    end
    exp_irq = 1'b0;
    for (int ch = 0; ch < N; ch++)
      if (m_stat[ch] && m_ctrl[ch][6]) exp_irq = 1'b1;
    a = int'(addr);
    mapped = (a < N + NS) || (LOCK_ON && a == N + NS);
    exp_rvalid = acc && !wr;
    exp_rdata  = (acc && !wr) ? read_val(a) : 8'd0;
    exp_err    = acc && (!mapped || (wr && a < N && m_lock));
    if (acc && wr) begin
      if (a < N) begin
        if (!m_lock) m_ctrl[a] = wd;
      end else if (a < N + NS) begin
        for (int b = 0; b < 8; b++) begin
          int ch;
          ch = (a - N) * 8 + b;
          if (ch < N && wd[b]) m_stat[ch] = 1'b0;
        end
      end else if (LOCK_ON && a == N + NS && wd[0]) begin
        m_lock = 1'b1;
      end
    end
    m_stat = m_stat | in_int;
  endtask

  function automatic logic [2*N-1:0] exp_ft();
    logic [2*N-1:0] r;
    for (int ch = 0; ch < N; ch++) r[2*ch +: 2] = m_ctrl[ch][1:0];
    return r;
  endfunction

  function automatic logic [4*N-1:0] exp_ws();
    logic [4*N-1:0] r;
    for (int ch = 0; ch < N; ch++) r[4*ch +: 4] = m_ctrl[ch][5:2];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_bit(input int pos);
    logic [N-1:0] r;
    for (int ch = 0; ch < N; ch++) r[ch] = m_ctrl[ch][pos];
    return r;
  endfunction

  // compare process: every cycle once the bank has been reset
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rdata", 64'(rdata), 64'(exp_rdata));
      chk("rvalid", 64'(rvalid), 64'(exp_rvalid));
      chk("err", 64'(err), 64'(exp_err));
      chk("irq", 64'(irq), 64'(exp_irq));
      chk("filter_type", 64'(ft), 64'(exp_ft()));
      chk("window_size", 64'(ws), 64'(exp_ws()));
      chk("int_en", 64'(ie), 64'(exp_bit(6)));
      chk("wd_rst", 64'(wdr), 64'(exp_bit(7)));
    end
  end

  task automatic cycle(input logic r, input logic a_en, input logic w, input int ad,
                       input logic [7:0] d, input logic [N-1:0] ii);
    rst    = r;
    acc    = a_en;
    wr     = w;
    addr   = ADDR_W'(ad);
    wd     = d;
    in_int = ii;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 0, 8'd0, '0);
  endtask

  task automatic rd(input int a);
    cycle(1'b0, 1'b1, 1'b0, a, 8'd0, '0);
  endtask

  task automatic wrt(input int a, input logic [7:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d, '0);
  endtask

  initial begin
    cycle(1'b1, 1'b1, 1'b0, 0, 8'hFF, '1);
    cycle(1'b1, 1'b0, 1'b0, 0, 8'd0, '0);
    chk("reset rvalid", 64'(rvalid), 64'd0);
    chk("reset rdata", 64'(rdata), 64'd0);
    chk("reset irq", 64'(irq), 64'd0);
    chk("reset filter_type", 64'(ft), 64'd0);

    for (int a = 0; a < N + NS; a++) begin
      rd(a);
      chk("reset read rvalid", 64'(rvalid), 64'd1);
      chk("reset read rdata", 64'(rdata), 64'd0);
    end
    idle();
    chk("idle rvalid", 64'(rvalid), 64'd0);

    wrt(3, 8'hC5);
    chk("ctrl write no rvalid", 64'(rvalid), 64'd0);
    rd(3);
    chk("ctrl3 rdata", 64'(rdata), 64'hC5);
    chk("ctrl3 filter_type", 64'(ft[7:6]), 64'h1);
    chk("ctrl3 window_size", 64'(ws[15:12]), 64'h1);
    chk("ctrl3 int_en", 64'(ie[3]), 64'd1);
    chk("ctrl3 wd_rst", 64'(wdr[3]), 64'd1);

    cycle(1'b0, 1'b0, 1'b0, 0, 8'd0, N'(4));
    rd(N);
    chk("status read 1", 64'(rdata), 64'h04);
    rd(N);
    chk("status read 2", 64'(rdata), 64'h04);
    wrt(N, 8'h04);
    rd(N);
    chk("status after w1c", 64'(rdata), 64'h00);

    cycle(1'b0, 1'b1, 1'b1, N, 8'h20, N'(32));
    rd(N);
    chk("set beats w1c", 64'(rdata), 64'h20);
    wrt(N, 8'h20);

    wrt(5, 8'h40);
    cycle(1'b0, 1'b0, 1'b0, 0, 8'd0, N'(32));
    chk("irq not yet", 64'(irq), 64'd0);
    idle();
    chk("irq set", 64'(irq), 64'd1);
    wrt(N, 8'h20);
    chk("irq held during w1c", 64'(irq), 64'd1);
    idle();
    chk("irq cleared", 64'(irq), 64'd0);

    rd(N + NS + 1);
    chk("unmapped read err", 64'(err), 64'd1);
    chk("unmapped read rvalid", 64'(rvalid), 64'd1);
    chk("unmapped read rdata", 64'(rdata), 64'd0);
    wrt(N + NS + 1, 8'hAA);
    chk("unmapped write err", 64'(err), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] ii;
      for (int b = 0; b < N; b++) ii[b] = ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, N + NS + 2)), 8'($urandom), ii);
    end

    cycle(1'b1, 1'b0, 1'b0, 0, 8'd0, '0);
    wrt(0, 8'h3C);
    wrt(N + NS, 8'h01);
`ifdef FILTER_REG_BANK_LOCK_EN
    chk("lock write err", 64'(err), 64'd0);
    wrt(0, 8'hFF);
    chk("locked ctrl write err", 64'(err), 64'd1);
    rd(0);
    chk("locked ctrl unchanged", 64'(rdata), 64'h3C);
    rd(N + NS);
    chk("lock readback", 64'(rdata), 64'h01);
`else
    chk("no-lock write err", 64'(err), 64'd1);
    wrt(0, 8'hFF);
    chk("ctrl write err", 64'(err), 64'd0);
    rd(0);
    chk("ctrl write took", 64'(rdata), 64'hFF);
    rd(N + NS);
    chk("no-lock read err", 64'(err), 64'd1);
    chk("no-lock read rdata", 64'(rdata), 64'd0);
`endif
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
